// File: rtl/tensor_result_packer.sv
// tensor_result_packer: requantizes int32 result triples to int8 and packs them into 10-lane words behind a 2-entry FIFO.
// Define RESULT_ROUND_EN for round-half-up requantization; default build truncates.
module tensor_result_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] acc0,
  input  logic [31:0] acc1,
  input  logic [31:0] acc2,
  input  logic [4:0]  shift,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] out_data,
  output logic [3:0]  out_count
);
  logic [3:0] p, p_n, l;
  logic [9:0][7:0] pack, pack_n, cur, nxt;
  logic fp, fp_n, accept, do_flush, push, pop, full, complete;
  logic [1:0] cnt, cnt_n;
  logic [83:0] e0, e1, e0_n, e1_n, push_word;
  logic [7:0] b [3];

  function automatic logic [7:0] requant(input logic [31:0] a, input logic [4:0] s);
    logic signed [32:0] v;
    v = {a[31], a};
`ifdef RESULT_ROUND_EN
    if (s != 5'd0) v = v + (33'sd1 <<< (s - 5'd1));
`endif
    v = v >>> s;
    return v > 33'sd127 ? 8'h7f : v < -33'sd128 ? 8'h80 : v[7:0];
  endfunction

  assign full = cnt == 2'd2;
  assign in_ready = !full && !fp;
  assign accept = in_valid && in_ready;
  assign do_flush = fp && !full;
  assign out_valid = cnt != 2'd0;
  assign pop = out_valid && out_ready;
  assign {out_count, out_data} = e0;

  always_comb begin
    b[0] = requant(acc0, shift);
    b[1] = requant(acc1, shift);
    b[2] = requant(acc2, shift);
    cur = pack;
    nxt = '0;
    l = '0;
    // bytes past lane 9 spill into the next word
    for (int i = 0; i < 3; i++) begin
      l = p + 4'(i);
      if (l < 4'd10) cur[l] = b[i];
      else nxt[l - 4'd10] = b[i];
    end
    complete = p >= 4'd7;
    push = accept ? complete : do_flush && p != 4'd0;
    push_word = accept ? {4'd10, cur} : {p, pack};
    p_n = accept ? (complete ? p - 4'd7 : p + 4'd3) : do_flush ? 4'd0 : p;
    pack_n = accept ? (complete ? nxt : cur) : do_flush ? '0 : pack;
    fp_n = flush || (fp && !do_flush);
    cnt_n = cnt + {1'b0, push} - {1'b0, pop};
    e0_n = push && (pop ? cnt == 2'd1 : cnt == 2'd0) ? push_word : pop && full ? e1 : e0;
    e1_n = push && (full || (cnt == 2'd1 && !pop)) ? push_word : e1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p <= '0;
      pack <= '0;
      fp <= 1'b0;
      cnt <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      p <= p_n;
      pack <= pack_n;
      fp <= fp_n;
      cnt <= cnt_n;
      e0 <= e0_n;
      e1 <= e1_n;
    end
endmodule

// File: tb/tb_tensor_result_packer.sv
// tb_tensor_result_packer: directed and random checks of tensor_result_packer against a byte-queue reference model.
module tb_tensor_result_packer;
  logic clk = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] acc0 = 0, acc1 = 0, acc2 = 0;
  logic [4:0] shift = 0;
  logic in_ready, out_valid;
  logic [79:0] out_data;
  logic [3:0] out_count;
  int errors = 0, checks = 0;
  logic [83:0] mq[$], got[$];
  logic [7:0] part[$];
  bit fp = 0;

  always #5 clk = ~clk;

  tensor_result_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .acc0(acc0), .acc1(acc1), .acc2(acc2), .shift(shift), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  function automatic logic [7:0] rq(logic [31:0] a, logic [4:0] s);
    longint v;
    v = longint'($signed(a));
`ifdef RESULT_ROUND_EN
    if (s > 0) v += longint'(1) << (s - 1);
`endif
    v = v >>> s;
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  function automatic logic [31:0] rnd();
    int k;
    k = $urandom_range(0, 2);
    return k == 0 ? $urandom : k == 1 ? $urandom_range(0, 600) - 300 : $urandom_range(0, 32'h000fffff);
  endfunction

  task automatic chk(string name, logic [83:0] act, logic [83:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic emit();
    logic [83:0] w;
    w = '0;
    foreach (part[k]) w[8*k +: 8] = part[k];
    w[83:80] = 4'(part.size());
    mq.push_back(w);
    part.delete();
  endtask

  task automatic add_byte(logic [7:0] x);
    part.push_back(x);
    if (part.size() == 10) emit();
  endtask

  // reference model: bytes stream into a partial word, completed words queue for output
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      part.delete();
      fp = 0;
    end else begin
      bit full, acc_ok, pop;
      full = mq.size() == 2;
      acc_ok = in_valid && !full && !fp;
      pop = mq.size() > 0 && out_ready;
      if (pop) void'(mq.pop_front());
      if (acc_ok) begin
        add_byte(rq(acc0, shift));
        add_byte(rq(acc1, shift));
        add_byte(rq(acc2, shift));
      end else if (fp && !full) begin
        if (part.size() > 0) emit();
        fp = 0;
      end
      if (flush) fp = 1;
    end
  end

  always @(negedge clk) if (!reset) begin
    chk("in_ready", 84'(in_ready), 84'(mq.size() < 2 && !fp));
    chk("out_valid", 84'(out_valid), 84'(mq.size() > 0));
    if (mq.size() > 0) chk("head", {out_count, out_data}, mq[0]);
    if (out_valid && out_ready) got.push_back({out_count, out_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [4:0] s, bit fl);
    int n;
    n = 0;
    acc0 = a; acc1 = b; acc2 = c; shift = s; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    flush = fl;
    tick();
    in_valid = 0;
    flush = 0;
  endtask

  task automatic pulse_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    reset = 0;
    @(negedge clk);
    chk("reset_out", {out_count, out_data}, 84'd0);
    chk("reset_flags", 84'({in_ready, out_valid}), 84'b10);
    tick();
    out_ready = 1;
    got.delete();
    repeat (4) send(1, 2, 3, 0, 0);
    repeat (3) tick();
    chk("pack_words", 84'(got.size()), 84'd1);
    chk("pack_word", got[0], {4'd10, 80'h01030201030201030201});
    pulse_flush();
    repeat (3) tick();
    chk("pack_rest", got[1], {4'd2, 80'h0302});
    got.delete();
    send(300, -32'sd300, 32'h7fffffff, 0, 0);
    pulse_flush();
    repeat (3) tick();
    chk("saturate", got[0], {4'd3, 80'h7f807f});
    got.delete();
    send(6, 5, -32'sd6, 2, 0);
    pulse_flush();
    repeat (3) tick();
`ifdef RESULT_ROUND_EN
    chk("round", got[0], {4'd3, 80'hff0102});
`else
    chk("round", got[0], {4'd3, 80'hfe0101});
`endif
    got.delete();
    repeat (2) send(9, 9, 9, 0, 0);
    pulse_flush();
    repeat (3) tick();
    chk("flush6", got[0], {4'd6, 80'h090909090909});
    got.delete();
    pulse_flush();
    repeat (4) tick();
    chk("flush_empty", 84'(got.size()), 84'd0);
    send(1, 1, 1, 0, 1);
    repeat (4) tick();
    chk("flush_with_accept", got[0], {4'd3, 80'h010101});
    got.delete();
    out_ready = 0;
    for (int k = 1; k <= 7; k++) send(k, k, k, 0, 0);
    acc0 = 8; acc1 = 8; acc2 = 8; in_valid = 1;
    repeat (3) tick();
    chk("bp_ready", 84'(in_ready), 84'd0);
    chk("bp_valid", 84'(out_valid), 84'd1);
    in_valid = 0;
    out_ready = 1;
    send(8, 8, 8, 0, 1);
    repeat (4) tick();
    chk("bp_w0", got[0], {4'd10, 80'h04030303020202010101});
    chk("bp_w1", got[1], {4'd10, 80'h07070606060505050404});
    chk("bp_w2", got[2], {4'd4, 80'h08080807});
    chk("bp_ready_back", 84'(in_ready), 84'd1);
    got.delete();
    repeat (2) send(1, 2, 3, 0, 0);
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("midreset_flags", 84'({in_ready, out_valid}), 84'b10);
    tick();
    repeat (4) send(1, 2, 3, 0, 0);
    repeat (3) tick();
    chk("midreset_words", 84'(got.size()), 84'd1);
    chk("midreset_word", got[0], {4'd10, 80'h01030201030201030201});
    pulse_flush();
    repeat (1500) begin
      tick();
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 11) == 0;
      shift = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      acc0 = rnd();
      acc1 = rnd();
      acc2 = rnd();
    end
    tick();
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    tick();
    pulse_flush();
    repeat (6) tick();
    @(negedge clk);
    chk("drained", 84'(out_valid), 84'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
